memory: RTL and testbench



---
 rtl/memory_if.sv | 32 +++
 rtl/memory.sv | 47 ++++
 tb/tb_memory.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/memory_if.sv
// Access bundle for the calculator data store: one read-or-write request per
// cycle from the datapath (master) and registered read data back from the RAM (slave).
interface memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input logic clk
);
  logic [DATA_WIDTH-1:0] din;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rw;
  logic                  valid;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    input  clk,
    output din,
    output addr,
    output rw,
    output valid,
    input  dout
  );

  modport slave (
    input  clk,
    input  din,
    input  addr,
    input  rw,
    input  valid,
    output dout
  );
endinterface

// File: rtl/memory.sv
// Single-port synchronous RAM for the binary calculator datapath: one access per
// cycle (rw=1 write, rw=0 read) gated by valid, registered read data, full clear on reset.
module memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rw,
  input  logic                  valid,
  input  logic                  reset,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;
  logic                  wr_en;

  assign wr_en = valid & rw;

  // dout only moves on a valid read; writes and idle cycles leave it holding.
  always_comb begin
    dout_d = dout_q;
    if (valid && !rw) begin
      dout_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      if (wr_en) begin
        mem[addr] <= din;
      end
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
endmodule

// File: tb/tb_memory.sv
// Bench for the calculator data store: directed scenarios plus a random burst,
// with expected dout values queued as each access is driven.
module tb_memory;
  logic clk;
  logic rst;

  memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) m (.clk(clk));

  memory #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .din   (m.din),
    .addr  (m.addr),
    .rw    (m.rw),
    .valid (m.valid),
    .reset (rst),
    .clk   (clk),
    .dout  (m.dout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl_mem [256];
  logic [31:0] mdl_dout;
  logic [31:0] want;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // Drive one access at the falling edge, queue the reference dout, then step
  // past the rising edge so outputs are sampled away from it.
  task automatic cyc(input logic r, input logic v, input logic w,
                     input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; m.valid = v; m.rw = w; m.addr = a; m.din = d;
    if (r) begin
      for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
      mdl_dout = '0;
    end else if (v && w) begin
      mdl_mem[a] = d;
    end else if (v) begin
      mdl_dout = mdl_mem[a];
    end
    exp_q.push_back(mdl_dout);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1, 8'h04, 32'h7);
    n_cmp++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    if (m.dout !== want) begin
      n_bad++; $display("FAIL reset_dout: got %h want %h", m.dout, want);
    end
    n_cmp++;
    if (dut.mem[4] !== 32'h0) begin
      n_bad++; $display("FAIL reset_mem4: got %h want %h", dut.mem[4], 32'h0);
    end
    n_cmp++;
    if (dut.mem[255] !== 32'h0) begin
      n_bad++; $display("FAIL reset_mem255: got %h want %h", dut.mem[255], 32'h0);
    end
  endtask

  task automatic test_read_cleared();
    cyc(1'b0, 1'b1, 1'b0, 8'h04, 32'h0);
    n_cmp++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    if (m.dout !== want || m.dout !== 32'h0) begin
      n_bad++; $display("FAIL read_cleared: got %h want %h", m.dout, 32'h0);
    end
  endtask

  task automatic test_write_read();
    cyc(1'b0, 1'b1, 1'b1, 8'h04, 32'h7);
    n_cmp++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    if (m.dout !== want) begin
      n_bad++; $display("FAIL write_dout_hold: got %h want %h", m.dout, want);
    end
    n_cmp++;
    if (dut.mem[4] !== 32'h7) begin
      n_bad++; $display("FAIL write_mem4: got %h want %h", dut.mem[4], 32'h7);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h04, 32'h0);
    n_cmp++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    if (m.dout !== want || m.dout !== 32'h7) begin
      n_bad++; $display("FAIL read_after_write: got %h want %h", m.dout, 32'h7);
    end
  endtask

  task automatic test_idle();
    cyc(1'b0, 1'b0, 1'b0, 8'h07, 32'h10);
    n_cmp++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    if (m.dout !== want || m.dout !== 32'h7) begin
      n_bad++; $display("FAIL idle_hold: got %h want %h", m.dout, 32'h7);
    end
    n_cmp++;
    if (dut.mem[7] !== 32'h0) begin
      n_bad++; $display("FAIL idle_mem7: got %h want %h", dut.mem[7], 32'h0);
    end
    // An idle write request must not land either.
    cyc(1'b0, 1'b0, 1'b1, 8'h07, 32'h10);
    n_cmp++;
    if (dut.mem[7] !== 32'h0) begin
      n_bad++; $display("FAIL idle_write_mem7: got %h want %h", dut.mem[7], 32'h0);
    end
    void'(exp_q.pop_front());
    cyc(1'b0, 1'b1, 1'b0, 8'h07, 32'h10);
    n_cmp++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    if (m.dout !== want || m.dout !== 32'h0) begin
      n_bad++; $display("FAIL idle_then_read: got %h want %h", m.dout, 32'h0);
    end
  endtask

  task automatic test_reset_after_data();
    cyc(1'b0, 1'b1, 1'b0, 8'h04, 32'h0);
    void'(exp_q.pop_front());
    cyc(1'b1, 1'b1, 1'b1, 8'h04, 32'hA5A5_A5A5);
    n_cmp++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    if (m.dout !== want || m.dout !== 32'h0) begin
      n_bad++; $display("FAIL reset_data_dout: got %h want %h", m.dout, 32'h0);
    end
    n_cmp++;
    if (dut.mem[4] !== 32'h0) begin
      n_bad++; $display("FAIL reset_data_mem4: got %h want %h", dut.mem[4], 32'h0);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h04, 32'h0);
    n_cmp++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    if (m.dout !== want || m.dout !== 32'h0) begin
      n_bad++; $display("FAIL reset_data_read4: got %h want %h", m.dout, 32'h0);
    end
  endtask

  task automatic test_boundary();
    logic [7:0]  ra [4];
    logic [31:0] rv [4];
    ra = '{8'h00, 8'hFF, 8'h01, 8'hFE};
    rv = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'h0};
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 32'hDEAD_BEEF);
    void'(exp_q.pop_front());
    cyc(1'b0, 1'b1, 1'b1, 8'hFF, 32'h1234_5678);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, ra[i], 32'h0);
      n_cmp++;
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      if (m.dout !== want || m.dout !== rv[i]) begin
        n_bad++; $display("FAIL boundary_read[%h]: got %h want %h", ra[i], m.dout, rv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 15)) | ((i % 2 == 0) ? 8'h00 : 8'hF0);
      cyc(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, $urandom);
      n_cmp++;
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      if (m.dout !== want) begin
        n_bad++; $display("FAIL back_to_back[%0d]: got %h want %h", i, m.dout, want);
      end
    end
  endtask

  initial begin
    rst = 1'b1; m.valid = 1'b0; m.rw = 1'b0; m.addr = '0; m.din = '0;
    mdl_dout = '0;
    test_reset();
    test_read_cleared();
    test_write_read();
    test_idle();
    test_reset_after_data();
    test_boundary();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
